// File: rtl/stable_matching_seq_pkg.sv
// Shared types and helpers for the sequential Gale-Shapley engine:
// width math, FSM states and flat-vector slice positions.
package stable_matching_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sm_state_e;

  // Ceiling log2 with a floor of 1 so a single-entry list still gets a bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int s_pref_pos(input int i, input int k, input int ks, input int logr);
    return (i * ks + k) * logr;
  endfunction

  function automatic int r_pref_pos(input int j, input int k, input int kr, input int logs);
    return (j * kr + k) * logs;
  endfunction

  function automatic int o_pos(input int j, input int logs);
    return j * logs;
  endfunction

endpackage

// File: rtl/stable_matching_seq_if.sv
// Request/result bundle between a host and the stable-matching engine.
interface stable_matching_seq_if #(
  parameter int S  = 8,
  parameter int R  = S,
  parameter int Ks = 8,
  parameter int Kr = 8
);
  import stable_matching_pkg::*;

  localparam int LOGS = clog2_min1(S);
  localparam int LOGR = clog2_min1(R);
  localparam int CW   = clog2_min1(S * Ks + 1);

  logic                   start;
  logic [S*Ks*LOGR-1:0]   s_pref;
  logic [R*Kr*LOGS-1:0]   r_pref;
  logic                   busy;
  logic                   done;
  logic [R*LOGS-1:0]      o;
  logic [R-1:0]           o_matched;
  logic [CW-1:0]          n_prop;

  modport master (output start, s_pref, r_pref,
                  input  busy, done, o, o_matched, n_prop);
  modport slave  (input  start, s_pref, r_pref,
                  output busy, done, o, o_matched, n_prop);

endinterface

// File: rtl/stable_matching_seq_rank_lookup.sv
// Combinational position of a proposer within one receiver's preference list;
// returns Kr when the proposer is absent.
module sm_rank_lookup #(
  parameter int Kr   = 8,
  parameter int LOGS = 3,
  parameter int RW   = 4
) (
  input  logic [Kr*LOGS-1:0] list,
  input  logic [LOGS-1:0]    idx,
  output logic [RW-1:0]      rank
);

  // Scan from the back so the earliest duplicate wins
  always_comb begin
    rank = RW'(Kr);
    for (int k = Kr - 1; k >= 0; k--)
      if (list[k*LOGS +: LOGS] == idx) rank = RW'(k);
  end

endmodule

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley engine: one proposal evaluated per RUN cycle,
// lowest-index free proposer first, with start/busy/done handshake.
module stable_matching_seq
  import stable_matching_pkg::*;
#(
  parameter int S  = 8,
  parameter int R  = S,
  parameter int Ks = 8,
  parameter int Kr = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stable_matching_seq_if.slave bus
);

  localparam int LOGS = clog2_min1(S);
  localparam int LOGR = clog2_min1(R);
  localparam int CW   = clog2_min1(S * Ks + 1);
  localparam int NW   = clog2_min1(Ks + 1);
  localparam int RW   = clog2_min1(Kr + 1);

  sm_state_e            state, state_nxt;
  logic [S*Ks*LOGR-1:0] s_pref_q;
  logic [R*Kr*LOGS-1:0] r_pref_q;
  logic [NW-1:0]        nxt [S];
  logic [S-1:0]         free;
  logic [R*LOGS-1:0]    partner;
  logic [R-1:0]         matched;
  logic [CW-1:0]        n_prop_q;

  logic                 found;
  logic [LOGS-1:0]      sel;
  logic [LOGR-1:0]      j_raw;
  logic [LOGR-1:0]      j_idx;
  logic                 j_valid;
  logic [Kr*LOGS-1:0]   j_list;
  logic [LOGS-1:0]      cur_partner;
  logic [RW-1:0]        rank_new;
  logic [RW-1:0]        rank_cur;
  logic                 accept;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = S - 1; i >= 0; i--)
      if (free[i] && nxt[i] < NW'(Ks)) begin
        found = 1'b1;
        sel   = LOGS'(i);
      end
  end

  // Out-of-range receivers are steered to slot 0 only to keep lookups legal
  always_comb begin
    j_raw       = s_pref_q[s_pref_pos(int'(sel), int'(nxt[sel]), Ks, LOGR) +: LOGR];
    j_valid     = int'(j_raw) < R;
    j_idx       = j_valid ? j_raw : '0;
    j_list      = r_pref_q[r_pref_pos(int'(j_idx), 0, Kr, LOGS) +: Kr*LOGS];
    cur_partner = partner[o_pos(int'(j_idx), LOGS) +: LOGS];
    accept      = found && j_valid && (int'(rank_new) < Kr) &&
                  (!matched[j_idx] || rank_new < rank_cur);
  end

  sm_rank_lookup #(.Kr(Kr), .LOGS(LOGS), .RW(RW)) u_rank_new (
    .list (j_list),
    .idx  (sel),
    .rank (rank_new)
  );

  sm_rank_lookup #(.Kr(Kr), .LOGS(LOGS), .RW(RW)) u_rank_cur (
    .list (j_list),
    .idx  (cur_partner),
    .rank (rank_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (!found)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accepting a proposal frees the displaced partner on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pref_q <= '0;
      r_pref_q <= '0;
      free     <= '0;
      partner  <= '0;
      matched  <= '0;
      n_prop_q <= '0;
      for (int i = 0; i < S; i++) nxt[i] <= '0;
    end else if (state == IDLE && bus.start) begin
      s_pref_q <= bus.s_pref;
      r_pref_q <= bus.r_pref;
      free     <= '1;
      partner  <= '0;
      matched  <= '0;
      n_prop_q <= '0;
      for (int i = 0; i < S; i++) nxt[i] <= '0;
    end else if (state == RUN && found) begin
      nxt[sel] <= nxt[sel] + 1'b1;
      n_prop_q <= n_prop_q + 1'b1;
      if (accept) begin
        free[sel] <= 1'b0;
        if (matched[j_idx]) free[cur_partner] <= 1'b1;
        partner[o_pos(int'(j_idx), LOGS) +: LOGS] <= sel;
        matched[j_idx] <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.o         = partner;
  assign bus.o_matched = matched;
  assign bus.n_prop    = n_prop_q;

endmodule

// File: tb/tb_stable_matching_seq.sv
// Bench for stable_matching_seq: a 4x4 and a 3x3 instance driven with directed
// and random preference tables, checked against a Gale-Shapley reference model.
module tb_stable_matching_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stable_matching_seq_if #(.S(4), .R(4), .Ks(4), .Kr(4)) bus4 ();
  stable_matching_seq_if #(.S(3), .R(3), .Ks(3), .Kr(3)) bus3 ();

  stable_matching_seq #(.S(4), .R(4), .Ks(4), .Kr(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  stable_matching_seq #(.S(3), .R(3), .Ks(3), .Kr(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int          total = 0;
  int          bad   = 0;
  int          sp [4][4];
  int          rp [4][4];
  int          exp_o [4];
  int          exp_m [4];
  int          exp_n;
  logic [31:0] got_o [4];
  logic [31:0] got_m [4];
  logic [31:0] got_n;
  int          got_lat;
  int          extra;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int nOf(input int w);
    return (w == 0) ? 4 : 3;
  endfunction

  function automatic logic outBusy(input int w);
    return (w == 0) ? bus4.busy : bus3.busy;
  endfunction

  function automatic logic outDone(input int w);
    return (w == 0) ? bus4.done : bus3.done;
  endfunction

  function automatic int rankOf(input int j, input int i, input int kr);
    for (int k = 0; k < kr; k++)
      if (rp[j][k] == i) return k;
    return kr;
  endfunction

  // Textbook Gale-Shapley over the bench's integer tables
  task automatic computeModel(input int w);
    int n;
    int nx [4];
    int fr [4];
    int i, j;
    n = nOf(w);
    exp_n = 0;
    for (int a = 0; a < 4; a++) begin
      nx[a] = 0; fr[a] = (a < n); exp_o[a] = 0; exp_m[a] = 0;
    end
    forever begin
      i = -1;
      for (int a = n - 1; a >= 0; a--)
        if (fr[a] != 0 && nx[a] < n) i = a;
      if (i < 0) break;
      j = sp[i][nx[i]];
      nx[i]++;
      exp_n++;
      if (j < n && rankOf(j, i, n) < n &&
          (exp_m[j] == 0 || rankOf(j, i, n) < rankOf(j, exp_o[j], n))) begin
        if (exp_m[j] != 0) fr[exp_o[j]] = 1;
        exp_o[j] = i;
        exp_m[j] = 1;
        fr[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] packList(input int n, input bit is_s);
    logic [31:0] v;
    v = '0;
    for (int a = 0; a < n; a++)
      for (int b = 0; b < n; b++)
        v[(a*n + b)*2 +: 2] = 2'(is_s ? sp[a][b] : rp[a][b]);
    return v;
  endfunction

  task automatic driveInputs(input int w);
    logic [31:0] vs, vr;
    vs = packList(nOf(w), 1'b1);
    vr = packList(nOf(w), 1'b0);
    if (w == 0) begin
      bus4.s_pref = vs;
      bus4.r_pref = vr;
    end else begin
      bus3.s_pref = vs[17:0];
      bus3.r_pref = vr[17:0];
    end
  endtask

  task automatic setStart(input int w, input logic v);
    if (w == 0) bus4.start = v;
    else        bus3.start = v;
  endtask

  task automatic capture(input int w);
    for (int j = 0; j < 4; j++) begin
      got_o[j] = '0;
      got_m[j] = '0;
    end
    if (w == 0) begin
      for (int j = 0; j < 4; j++) begin
        got_o[j] = 32'(bus4.o[j*2 +: 2]);
        got_m[j] = 32'(bus4.o_matched[j]);
      end
      got_n = 32'(bus4.n_prop);
    end else begin
      for (int j = 0; j < 3; j++) begin
        got_o[j] = 32'(bus3.o[j*2 +: 2]);
        got_m[j] = 32'(bus3.o_matched[j]);
      end
      got_n = 32'(bus3.n_prop);
    end
  endtask

  // Start is sampled on the posedge between the two negedges
  task automatic applyStimulus(input int w);
    @(negedge clk);
    driveInputs(w);
    setStart(w, 1'b1);
    @(negedge clk);
    setStart(w, 1'b0);
  endtask

  // Entered at the negedge of the first busy cycle; leaves at the done cycle
  task automatic waitDone(input int w, input int disturb_at, input string tag);
    got_lat = 1;
    checkValue({tag, ".busy"}, 32'(outBusy(w)), 1);
    while (outDone(w) !== 1'b1 && got_lat < 200) begin
      setStart(w, got_lat == disturb_at);
      if (got_lat == disturb_at) begin
        if (w == 0) bus4.s_pref = $urandom;
        else        bus3.s_pref = 18'($urandom);
      end
      @(negedge clk);
      got_lat++;
    end
    setStart(w, 1'b0);
    checkValue({tag, ".done"}, 32'(outDone(w)), 1);
    checkValue({tag, ".lat"}, got_lat, exp_n + 2);
    capture(w);
  endtask

  task automatic checkOutput(input int w, input string tag);
    for (int j = 0; j < nOf(w); j++) begin
      checkValue($sformatf("%s.m%0d", tag, j), got_m[j], exp_m[j]);
      checkValue($sformatf("%s.o%0d", tag, j), got_o[j], exp_o[j]);
    end
    checkValue({tag, ".n"}, got_n, exp_n);
  endtask

  task automatic doRun(input int w, input int disturb_at, input string tag);
    computeModel(w);
    applyStimulus(w);
    waitDone(w, disturb_at, tag);
    checkOutput(w, tag);
  endtask

  task automatic setContention();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        sp[a][b] = b;
        rp[a][b] = 3 - b;
      end
  endtask

  task automatic checkCleared(input string tag);
    checkValue({tag, ".busy"}, 32'(bus4.busy), 0);
    checkValue({tag, ".done"}, 32'(bus4.done), 0);
    checkValue({tag, ".o"}, 32'(bus4.o), 0);
    checkValue({tag, ".om"}, 32'(bus4.o_matched), 0);
    checkValue({tag, ".n"}, 32'(bus4.n_prop), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.s_pref = '0; bus4.r_pref = '0;
    bus3.start = 1'b0; bus3.s_pref = '0; bus3.r_pref = '0;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    checkValue("reset.o3", 32'(bus3.o), 0);
    rst_n = 1'b1;

    // Identity: everyone's first choice is mutual
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        sp[a][b] = (a + b) % 4;
        rp[a][b] = (a + b) % 4;
      end
    doRun(0, -1, "ident");
    checkValue("ident.lat6", got_lat, 6);

    setContention();
    doRun(0, -1, "cont");
    checkValue("cont.n10", got_n, 10);
    checkValue("cont.lat12", got_lat, 12);

    // Receiver 1 lists only the invalid index; index 3 is not a receiver
    sp[0][0] = 1; sp[0][1] = 3; sp[0][2] = 0;
    sp[1][0] = 3; sp[1][1] = 1; sp[1][2] = 2;
    sp[2][0] = 1; sp[2][1] = 0; sp[2][2] = 2;
    rp[0][0] = 0; rp[0][1] = 1; rp[0][2] = 2;
    rp[1][0] = 3; rp[1][1] = 3; rp[1][2] = 3;
    rp[2][0] = 2; rp[2][1] = 1; rp[2][2] = 0;
    doRun(1, -1, "unacc");
    checkValue("unacc.m1", got_m[1], 0);

    // Start pulse and input change mid-run must not disturb the result
    setContention();
    doRun(0, 3, "busystart");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus4.done === 1'b1) extra++;
    end
    checkValue("busystart.extra_done", extra, 0);
    checkValue("busystart.hold_n", 32'(bus4.n_prop), 10);

    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          sp[a][b] = $urandom_range(0, 3);
          rp[a][b] = $urandom_range(0, 3);
        end
      doRun(0, -1, $sformatf("rand4_%0d", r));
    end
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) begin
          sp[a][b] = $urandom_range(0, 3);
          rp[a][b] = $urandom_range(0, 3);
        end
      doRun(1, -1, $sformatf("rand3_%0d", r));
    end

    // Reset asserted mid-run clears everything without waiting for a clock
    setContention();
    applyStimulus(0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkCleared("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    doRun(0, -1, "afterrst");

    // Start during done is dropped; start one cycle later is taken
    setContention();
    doRun(0, -1, "b2b_a");
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        sp[a][b] = (a + b) % 4;
        rp[a][b] = (a + b) % 4;
      end
    driveInputs(0);
    bus4.start = 1'b1;
    @(negedge clk);
    checkValue("b2b.ignored_busy", 32'(bus4.busy), 0);
    checkValue("b2b.hold_n", 32'(bus4.n_prop), 10);
    checkValue("b2b.hold_o0", 32'(bus4.o[1:0]), 3);
    @(negedge clk);
    bus4.start = 1'b0;
    computeModel(0);
    waitDone(0, -1, "b2b_b");
    checkOutput(0, "b2b_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
